// File: rtl/seg7_scan_hex_pkg.sv
// Shared constants for the 7-segment display stages.
// SEG_CODES holds the active-low {dp,g,f,e,d,c,b,a} pattern for each hex
// digit, indexed by nibble value. The decimal point is always off (bit 7 = 1).
package seg7_scan_hex_pkg;

  localparam int unsigned NUM_DIGITS = 8;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] DIG_OFF = 8'hFF;

  // Entry 15 is the most significant slice of the packed vector.
  localparam logic [15:0][7:0] SEG_CODES = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg7_scan_hex_hex_to_seg7.sv
// hex_to_seg7: combinational hex-nibble to active-low 7-segment decoder.
// Ports:
//   hex - 4-bit value to show
//   seg - active-low segments {dp,g,f,e,d,c,b,a}, dp always off
module hex_to_seg7
  import seg7_scan_hex_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_CODES[hex];
  end

endmodule

// File: rtl/seg7_scan_hex.sv
// seg7_scan_hex: scans a 32-bit value onto an 8-digit multiplexed
// common-anode 7-segment display in hexadecimal, one digit per SCAN_DIV
// clocks. The value is snapshotted at each frame boundary so a frame never
// mixes old and new data. Leading-zero blanking is optional.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset
//   data     - value to display, nibble 0 = rightmost digit
//   disp_en  - 1 = display on, 0 = all digits off (scanning continues)
//   blank_lz - 1 = suppress leading zero digits (digit 0 never blanked)
//   led_en   - active-low digit enables, bit i = digit i
//   seg      - active-low segments {dp,g,f,e,d,c,b,a}
module seg7_scan_hex
  import seg7_scan_hex_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic        disp_en,
  input  logic        blank_lz,
  output logic [7:0]  led_en,
  output logic [7:0]  seg
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       idx;
  logic [31:0]      snap;
  logic             tick;

  logic [3:0]       cur_nib;
  logic [31:0]      upper;
  logic             blank;
  logic [7:0]       seg_dec;
  logic [7:0]       led_nxt;
  logic [7:0]       seg_nxt;

  assign tick = (div_cnt == DIV_W'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
      snap    <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) begin
        idx <= idx + 3'd1;
        // Capture on the same edge that wraps idx 7 -> 0.
        if (idx == 3'(NUM_DIGITS - 1)) begin
          snap <= data;
        end
      end
    end
  end

  hex_to_seg7 u_dec (
    .hex (cur_nib),
    .seg (seg_dec)
  );

  always_comb begin
    cur_nib = snap[{idx, 2'b00} +: 4];
    // A digit is a leading zero when it and every nibble above it are zero.
    upper   = snap >> {idx, 2'b00};
    blank   = blank_lz && (idx != 3'd0) && (upper == '0);
    led_nxt = DIG_OFF;
    seg_nxt = SEG_OFF;
    if (disp_en && !blank) begin
      led_nxt = ~(8'b1 << idx);
      seg_nxt = seg_dec;
    end
  end

  // led_en and seg share one register stage so they switch together.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_en <= DIG_OFF;
      seg    <= SEG_OFF;
    end else begin
      led_en <= led_nxt;
      seg    <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_hex.sv
// Testbench for seg7_scan_hex with SCAN_DIV = 4. A reference model tracks
// the number of clocks since reset and the captured frame value; the digit
// shown and its pattern are derived arithmetically from those.
module tb_seg7_scan_hex;

  localparam int D     = 4;
  localparam int FRAME = 8 * D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = '0;
  logic        disp_en = 1'b1;
  logic        blank_lz = 1'b0;
  logic [7:0]  led_en;
  logic [7:0]  seg;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          m      = 0;   // clocks since reset release
  logic [31:0] snap_m = '0;  // value shown in the current frame

  logic [7:0] seg_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  seg7_scan_hex #(.SCAN_DIV(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .disp_en  (disp_en),
    .blank_lz (blank_lz),
    .led_en   (led_en),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
    end
  endtask

  // One clock: predict from pre-edge state and inputs, advance model, compare.
  task automatic step();
    logic [7:0]  el;
    logic [7:0]  es;
    logic [31:0] up;
    logic [3:0]  nib;
    int          i;
    el = 8'hFF;
    es = 8'hFF;
    if (!rst) begin
      i   = (m / D) % 8;
      up  = snap_m >> (4 * i);
      nib = 4'(up);
      if (disp_en && !(blank_lz && i != 0 && up == 0)) begin
        el = ~(8'(1) << i);
        es = seg_tab[nib];
      end
    end
    @(posedge clk);
    if (rst) begin
      m      = 0;
      snap_m = '0;
    end else begin
      if (m % FRAME == FRAME - 1) snap_m = data;
      m++;
    end
    #1;
    cyc++;
    check("led_en", led_en, el);
    check("seg", seg, es);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic run_to_phase(input int ph);
    for (int k = 0; k < FRAME && (m % FRAME) != ph; k++) step();
  endtask

  initial begin
    // 1: reset then 12345678 without blanking
    data = 32'h1234_5678; disp_en = 1'b1; blank_lz = 1'b0; rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(1);
    check("t1_c1_led", led_en, 8'hFE);
    check("t1_c1_seg", seg, 8'hC0);
    run(4);
    check("t1_c5_led", led_en, 8'hFD);
    run(28);
    check("t1_c33_led", led_en, 8'hFE);
    check("t1_c33_seg", seg, 8'h80);
    run(4);
    check("t1_c37_led", led_en, 8'hFD);
    check("t1_c37_seg", seg, 8'hF8);
    run(24);
    check("t1_c61_led", led_en, 8'h7F);
    check("t1_c61_seg", seg, 8'hF9);
    run(3);

    // 2: 000000A5 with blanking
    data = 32'h0000_00A5; blank_lz = 1'b1;
    run(33);
    check("t2_d0_seg", seg, 8'h92);
    run(4);
    check("t2_d1_seg", seg, 8'h88);
    run(4);
    check("t2_d2_led", led_en, 8'hFF);
    check("t2_d2_seg", seg, 8'hFF);
    run(23);

    // 3: zero with blanking keeps digit 0
    data = '0;
    run(33);
    check("t3_d0_led", led_en, 8'hFE);
    check("t3_d0_seg", seg, 8'hC0);
    run(4);
    check("t3_d1_led", led_en, 8'hFF);
    run(27);

    // 4: data change mid-frame is held off until the boundary
    blank_lz = 1'b0; data = 32'h1111_1111;
    run(32);
    run_to_phase(12);
    data = 32'hFFFF_FFFF;
    run(20);
    check("t4_old_seg", seg, 8'hF9);
    run(1);
    check("t4_new_seg", seg, 8'h8E);
    run(31);

    // 5: display off for a frame, re-enabled mid-frame
    disp_en = 1'b0;
    run(FRAME + 10);
    disp_en = 1'b1;
    run(1);
    run_to_phase(0);

    // 6: reset at idx 5
    data = 32'h89AB_CDEF;
    run_to_phase(20);
    rst = 1'b1;
    run(1);
    check("t6_rst_led", led_en, 8'hFF);
    check("t6_rst_seg", seg, 8'hFF);
    rst = 1'b0;
    run(1);
    check("t6_rel_led", led_en, 8'hFE);
    check("t6_rel_seg", seg, 8'hC0);
    run(40);

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 7) == 0)
        data = $urandom >> (4 * $urandom_range(0, 8));
      disp_en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    run(FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
